// File: rtl/jzjpcc_memory_access_pkg.sv
// Shared definitions for the memory-access stage.
//   - funct3 encodings for RV32I loads/stores
//   - two-state FSM type for split (misaligned) accesses
//   - size/misalignment helpers and value<->lane conversion
// Lane order: the byte at address offset k sits in bits [8(3-k)+7:8(3-k)]
// and is enabled by mask bit 3-k.
package jzjpcc_memory_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } mau_state_e;

  // Undefined funct3 encodings behave as a word access.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return ({1'b0, offset} + access_size(funct3)) > 3'd4;
  endfunction

  // Self-inverse byte swap between value order and lane order.
  function automatic logic [31:0] to_big_endian32(input logic [31:0] value);
    return {value[7:0], value[15:8], value[23:16], value[31:24]};
  endfunction

  // Two-word lane view: combined offsets 0..7, first word in the upper half.
  function automatic logic [7:0] lane_mask8(input logic [2:0] funct3, input logic [1:0] offset);
    logic [7:0] m;
    case (access_size(funct3))
      3'd1:    m = 8'h80;
      3'd2:    m = 8'hC0;
      default: m = 8'hF0;
    endcase
    return m >> offset;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset,
                                           input logic second);
    logic [7:0] m;
    m = lane_mask8(funct3, offset);
    return second ? m[3:0] : m[7:4];
  endfunction

  // Store data for the first or second word; lanes outside the access are zero.
  function automatic logic [31:0] lane_data(input logic [31:0] value, input logic [2:0] funct3,
                                            input logic [1:0] offset, input logic second);
    logic [7:0]  m;
    logic [63:0] d;
    m = lane_mask8(funct3, offset);
    d = {to_big_endian32(value), 32'h0} >> {offset, 3'b000};
    for (int k = 0; k < 8; k++) begin
      if (!m[7-k]) d[8*(7-k) +: 8] = 8'h00;
    end
    return second ? d[31:0] : d[63:32];
  endfunction

endpackage

// File: rtl/jzjpcc_load_extender.sv
// Combinational load result assembly.
//   first_word  : word holding the byte at the access offset (SRAM lane order)
//   second_word : upper three lanes of the following word (split loads only)
//   offset      : byte offset of the access within first_word
//   funct3      : load type, selects width and sign/zero extension
//   result      : extended load value in value order
module jzjpcc_load_extender
  import jzjpcc_memory_access_pkg::*;
(
  input  logic [31:0] first_word,
  input  logic [31:8] second_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] sel;
  logic [31:0] value;

  always_comb begin
    // Bring the byte at the access offset to the top lane, spilling into the next word.
    case (offset)
      2'd0:    sel = first_word;
      2'd1:    sel = {first_word[23:0], second_word[31:24]};
      2'd2:    sel = {first_word[15:0], second_word[31:16]};
      default: sel = {first_word[7:0],  second_word[31:8]};
    endcase
    value = to_big_endian32(sel);
    case (funct3)
      F3_B:    result = {{24{value[7]}}, value[7:0]};
      F3_BU:   result = {24'h0, value[7:0]};
      F3_H:    result = {{16{value[15]}}, value[15:0]};
      F3_HU:   result = {16'h0, value[15:0]};
      default: result = value;
    endcase
  end

endmodule

// File: rtl/jzjpcc_memory_access_unit.sv
// Memory-stage load/store initiator in front of the backend data port.
// Turns an execute-stage load/store into word-addressed, byte-masked requests;
// misaligned accesses are split over two cycles with a one-cycle stall.
//   clock, reset (async, active-low)
//   *_execute inputs        : access from execute (held stable while stalled)
//   memAddress/memDataToWrite/memByteMask/memWriteEnable : backend request
//   memReadData             : backend read word, one cycle after its address
//   stallRequest            : freeze upstream for the split access
//   loadResult/loadResultValid : extended load value
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | requests come straight from execute inputs
// ST_SECOND | second word of a split access, driven from registers
module jzjpcc_memory_access_unit
  import jzjpcc_memory_access_pkg::*;
#(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        accessValid_execute,
  input  logic        isStore_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [31:0] byteAddress_execute,
  input  logic [31:0] storeValue_execute,
  output logic [31:2] memAddress_execute_frommemory,
  output logic [31:0] memDataToWrite_execute_frommemory,
  output logic [3:0]  memByteMask_execute_frommemory,
  output logic        memWriteEnable,
  input  logic [31:0] memReadData,
  output logic        stallRequest,
  output logic [31:0] loadResult,
  output logic        loadResultValid
);

  localparam int HI_W = 30 - RAM_A_WIDTH;

  mau_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic        split_q, split_d;
  logic [29:0] addr_next_q, addr_next_d;
  logic [31:0] store_val_q, store_val_d;
  logic [31:0] hold_q, hold_d;
  logic        load_valid_q, load_valid_d;

  logic        misaligned_x;
  logic [RAM_A_WIDTH:0] ram_inc;
  logic [HI_W-1:0]      hi_inc;
  logic [29:0] word_addr_inc;
  logic [29:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic        req_we;
  logic        req_stall;
  logic [31:0] first_word;
  logic [31:8] second_word;
  logic [31:0] ext_result;

  assign misaligned_x = is_misaligned(funct3_execute, byteAddress_execute[1:0]);

  // Carry out of the SRAM word field ripples into the pass-through bits so the
  // whole word address wraps 0x3FFFFFFF -> 0.
  assign ram_inc       = {1'b0, byteAddress_execute[RAM_A_WIDTH+1:2]} + (RAM_A_WIDTH+1)'(1);
  assign hi_inc        = byteAddress_execute[31:RAM_A_WIDTH+2] + HI_W'(ram_inc[RAM_A_WIDTH]);
  assign word_addr_inc = {hi_inc, ram_inc[RAM_A_WIDTH-1:0]};

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    store_d      = store_q;
    split_d      = split_q;
    addr_next_d  = addr_next_q;
    store_val_d  = store_val_q;
    hold_d       = hold_q;
    load_valid_d = 1'b0;
    req_addr     = byteAddress_execute[31:2];
    req_data     = '0;
    req_mask     = '0;
    req_we       = 1'b0;
    req_stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accessValid_execute) begin
          req_mask     = lane_mask(funct3_execute, byteAddress_execute[1:0], 1'b0);
          req_data     = isStore_execute ?
                         lane_data(storeValue_execute, funct3_execute, byteAddress_execute[1:0], 1'b0) : '0;
          req_we       = isStore_execute;
          req_stall    = misaligned_x;
          // Metadata is kept for every access: the load result of an aligned
          // access and both halves of a split access are formed from it.
          off_d        = byteAddress_execute[1:0];
          funct3_d     = funct3_execute;
          store_d      = isStore_execute;
          split_d      = misaligned_x;
          addr_next_d  = word_addr_inc;
          store_val_d  = storeValue_execute;
          load_valid_d = !isStore_execute && !misaligned_x;
          if (misaligned_x) state_d = ST_SECOND;
        end
      end
      ST_SECOND: begin
        req_addr     = addr_next_q;
        req_mask     = lane_mask(funct3_q, off_q, 1'b1);
        req_data     = store_q ? lane_data(store_val_q, funct3_q, off_q, 1'b1) : '0;
        req_we       = store_q;
        hold_d       = memReadData;
        load_valid_d = !store_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      funct3_q     <= '0;
      store_q      <= 1'b0;
      split_q      <= 1'b0;
      addr_next_q  <= '0;
      store_val_q  <= '0;
      hold_q       <= '0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      store_q      <= store_d;
      split_q      <= split_d;
      addr_next_q  <= addr_next_d;
      store_val_q  <= store_val_d;
      hold_q       <= hold_d;
      load_valid_q <= load_valid_d;
    end
  end

  assign first_word  = split_q ? hold_q : memReadData;
  assign second_word = split_q ? memReadData[31:8] : 24'h0;

  jzjpcc_load_extender u_load_extender (
    .first_word  (first_word),
    .second_word (second_word),
    .offset      (off_q),
    .funct3      (funct3_q),
    .result      (ext_result)
  );

  // The request path is combinational from execute, so it is gated to keep
  // the backend quiet while reset is held.
  assign memAddress_execute_frommemory     = reset ? req_addr : '0;
  assign memDataToWrite_execute_frommemory = reset ? req_data : '0;
  assign memByteMask_execute_frommemory    = reset ? req_mask : '0;
  assign memWriteEnable                    = reset & req_we;
  assign stallRequest                      = reset & req_stall;
  assign loadResultValid                   = load_valid_q;
  assign loadResult                        = (reset && load_valid_q) ? ext_result : '0;

endmodule

// File: tb/tb_jzjpcc_memory_access_unit.sv
module tb_jzjpcc_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        accessValid_execute;
  logic        isStore_execute;
  logic [2:0]  funct3_execute;
  logic [31:0] byteAddress_execute;
  logic [31:0] storeValue_execute;
  logic [31:2] memAddress_execute_frommemory;
  logic [31:0] memDataToWrite_execute_frommemory;
  logic [3:0]  memByteMask_execute_frommemory;
  logic        memWriteEnable;
  logic [31:0] memReadData;
  logic        stallRequest;
  logic [31:0] loadResult;
  logic        loadResultValid;

  always #5 clock = ~clock;

  jzjpcc_memory_access_unit #(.RAM_A_WIDTH(12)) dut (
    .clock                             (clock),
    .reset                             (reset),
    .accessValid_execute               (accessValid_execute),
    .isStore_execute                   (isStore_execute),
    .funct3_execute                    (funct3_execute),
    .byteAddress_execute               (byteAddress_execute),
    .storeValue_execute                (storeValue_execute),
    .memAddress_execute_frommemory     (memAddress_execute_frommemory),
    .memDataToWrite_execute_frommemory (memDataToWrite_execute_frommemory),
    .memByteMask_execute_frommemory    (memByteMask_execute_frommemory),
    .memWriteEnable                    (memWriteEnable),
    .memReadData                       (memReadData),
    .stallRequest                      (stallRequest),
    .loadResult                        (loadResult),
    .loadResultValid                   (loadResultValid)
  );

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        we;
    logic        stall;
  } req_t;

  typedef struct {
    logic [31:0] value;
    int          due;
  } res_t;

  req_t exp_req[$];
  res_t exp_res[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  logic mon_en     = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'hA5000000 | 32'(i);
    if (i == 'h400) w[7:0]   = 8'h01;
    if (i == 'h401) w[31:24] = 8'h80;
    if (i == 1)     w        = 32'h000000F0;
    return w;
  endfunction

  // Backend model: registered read, byte-masked write.
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
  end

  always @(posedge clock) begin
    memReadData <= mem[memAddress_execute_frommemory[13:2]];
    if (memWriteEnable) begin
      for (int k = 0; k < 4; k++) begin
        if (memByteMask_execute_frommemory[3-k])
          mem[memAddress_execute_frommemory[13:2]][8*(3-k) +: 8] <= memDataToWrite_execute_frommemory[8*(3-k) +: 8];
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Byte-level reference: walk the access byte by byte over the address space.
  task automatic push_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] v, output logic mis);
    int size;
    int o;
    int k;
    req_t r1;
    req_t r2;
    logic [31:0] ba;
    logic [31:0] ld;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o    = int'(a[1:0]);
    mis  = (o + size > 4);
    r1   = '{addr: a[31:2], mask: 4'h0, data: 32'h0, we: st, stall: mis};
    r2   = '{addr: a[31:2] + 30'd1, mask: 4'h0, data: 32'h0, we: st, stall: 1'b0};
    ld   = 32'h0;
    for (int i = 0; i < size; i++) begin
      ba = a + 32'(i);
      k  = int'(ba[1:0]);
      if (o + i < 4) begin
        r1.mask[3-k] = 1'b1;
        if (st) r1.data[8*(3-k) +: 8] = v[8*i +: 8];
      end else begin
        r2.mask[3-k] = 1'b1;
        if (st) r2.data[8*(3-k) +: 8] = v[8*i +: 8];
      end
      if (st) ref_mem[ba[13:2]][8*(3-k) +: 8] = v[8*i +: 8];
      else    ld[8*i +: 8] = ref_mem[ba[13:2]][8*(3-k) +: 8];
    end
    if (!f3[2] && size == 1) ld = {{24{ld[7]}}, ld[7:0]};
    if (!f3[2] && size == 2) ld = {{16{ld[15]}}, ld[15:0]};
    exp_req.push_back(r1);
    if (mis) exp_req.push_back(r2);
    if (!st) exp_res.push_back('{value: ld, due: cyc + (mis ? 2 : 1)});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
    logic mis;
    accessValid_execute = 1'b1;
    isStore_execute     = st;
    funct3_execute      = f3;
    byteAddress_execute = a;
    storeValue_execute  = v;
    push_op(st, f3, a, v, mis);
    step();
    if (mis) step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      accessValid_execute = 1'b0;
      isStore_execute     = 1'($urandom);
      funct3_execute      = 3'($urandom);
      byteAddress_execute = $urandom;
      storeValue_execute  = $urandom;
      exp_req.push_back('{addr: 30'h0, mask: 4'h0, data: 32'h0, we: 1'b0, stall: 1'b0});
      step();
    end
  endtask

  always @(negedge clock) begin
    req_t e;
    res_t r;
    if (mon_en) begin
      if (exp_req.size() == 0) begin
        check_val("req_queue", 32'(exp_req.size()), 32'd1);
      end else begin
        e = exp_req.pop_front();
        check_val("mask",  32'(memByteMask_execute_frommemory), 32'(e.mask));
        check_val("we",    32'(memWriteEnable), 32'(e.we));
        check_val("stall", 32'(stallRequest), 32'(e.stall));
        if (e.mask != 4'h0) check_val("addr", 32'(memAddress_execute_frommemory), 32'(e.addr));
        if (e.we) check_val("wdata", memDataToWrite_execute_frommemory, e.data);
      end
      if (loadResultValid) begin
        if (exp_res.size() == 0) begin
          check_val("res_unexpected", 32'(loadResultValid), 32'(exp_res.size()));
        end else begin
          r = exp_res.pop_front();
          check_val("load_result", loadResult, r.value);
          check_val("load_cycle", 32'(cyc), 32'(r.due));
        end
      end else if (exp_res.size() != 0 && exp_res[0].due <= cyc) begin
        r = exp_res.pop_front();
        check_val("load_valid", 32'(loadResultValid), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1);
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);

    // Execute presents a store while reset is held: nothing may reach the backend.
    accessValid_execute = 1'b1;
    isStore_execute     = 1'b1;
    funct3_execute      = 3'b010;
    byteAddress_execute = 32'h0000_2001;
    storeValue_execute  = 32'h1234_5678;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("reset_mask",  32'(memByteMask_execute_frommemory), 32'h0);
    check_val("reset_we",    32'(memWriteEnable), 32'h0);
    check_val("reset_stall", 32'(stallRequest), 32'h0);
    check_val("reset_valid", 32'(loadResultValid), 32'h0);
    @(posedge clock);
    #1;
    accessValid_execute = 1'b0;
    reset  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    op(1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344);
    op(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB);
    op(1'b0, 3'b001, 32'h0000_1003, 32'h0);
    op(1'b0, 3'b101, 32'h0000_1003, 32'h0);
    op(1'b1, 3'b010, 32'h0000_2001, 32'hDEAD_BEEF);
    idle(1);
    op(1'b0, 3'b000, 32'h0000_0007, 32'h0);
    op(1'b0, 3'b100, 32'h0000_0007, 32'h0);
    op(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    op(1'b0, 3'b001, 32'h0000_0102, 32'h0);
    op(1'b0, 3'b101, 32'h0000_0100, 32'h0);
    op(1'b0, 3'b010, 32'h0000_2001, 32'h0);
    op(1'b0, 3'b000, 32'h0000_2004, 32'h0);
    op(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    op(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
    op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
    op(1'b1, 3'b001, 32'h0000_3003, 32'h0000_BEEF);
    op(1'b0, 3'b101, 32'h0000_3003, 32'h0);
    op(1'b0, 3'b111, 32'h0000_3002, 32'h0);

    for (int n = 0; n < 40; n++) begin
      a = 32'h0000_3000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) idle(1);
      else op(1'($urandom), 3'($urandom), a, $urandom);
    end
    idle(3);

    // Reset while the second half of a split store is pending.
    mon_en = 1'b0;
    accessValid_execute = 1'b1;
    isStore_execute     = 1'b1;
    funct3_execute      = 3'b010;
    byteAddress_execute = 32'h0000_2F01;
    storeValue_execute  = 32'h5566_7788;
    @(negedge clock);
    check_val("rst_first_stall", 32'(stallRequest), 32'h1);
    check_val("rst_first_mask",  32'(memByteMask_execute_frommemory), 32'h7);
    check_val("rst_first_we",    32'(memWriteEnable), 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_mid_we",     32'(memWriteEnable), 32'h0);
    check_val("rst_mid_mask",   32'(memByteMask_execute_frommemory), 32'h0);
    check_val("rst_mid_stall",  32'(stallRequest), 32'h0);
    check_val("rst_mid_valid",  32'(loadResultValid), 32'h0);
    check_val("rst_mid_result", loadResult, 32'h0);
    @(posedge clock);
    #1;
    accessValid_execute = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    w0 = init_word('hBC0);
    check_val("rst_first_write", mem['hBC0], {w0[31:24], 24'h887766});
    check_val("rst_no_second",   mem['hBC1], init_word('hBC1));
    mon_en = 1'b1;
    idle(1);
    op(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    op(1'b0, 3'b010, 32'h0000_2001, 32'h0);
    idle(3);

    mon_en = 1'b0;
    check_val("req_q_drained", 32'(exp_req.size()), 32'h0);
    check_val("res_q_drained", 32'(exp_res.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jzjpcc_memory_access_unit.md
# jzjpcc_memory_access_unit

Memory-stage initiator for load/store instructions: converts an RV32I load/store from execute into the word-addressed, byte-masked request that jzjpcc_memory_backend latches, and turns the returned SRAM word into a sign/zero-extended load result. Misaligned halfword and word accesses are split into two consecutive word accesses, with the pipeline stalled for one cycle. Sits between the execute/memory pipeline registers and the backend's data port (port B).

## Interface
- RAM_A_WIDTH, 12: backend SRAM word-address width; only address bits [RAM_A_WIDTH+1:2] are significant, upper bits are passed through unchanged.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low.
- accessValid_execute  in  1  execute holds a load or store this cycle.
- isStore_execute  in  1  1 = store, 0 = load.
- funct3_execute  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is treated as W.
- byteAddress_execute  in  32  effective byte address.
- storeValue_execute  in  32  rs2 value, native (value) order.
- memAddress_execute_frommemory  out  [31:2]  word address to backend.
- memDataToWrite_execute_frommemory  out  32  store data in SRAM lane order.
- memByteMask_execute_frommemory  out  4  byte-lane enables.
- memWriteEnable  out  1  store strobe.
- memReadData  in  32  backend read word, SRAM lane order, valid the cycle after its address.
- stallRequest  out  1  hold execute inputs and freeze upstream pipeline.
- loadResult  out  32  extended load value.
- loadResultValid  out  1  loadResult is meaningful this cycle.

## Operation
- Lane order: byte at address offset k occupies memReadData/memDataToWrite bits [8(3-k)+7:8(3-k)], enabled by mask bit 3-k. Value-to-lane conversion uses toBigEndian32 from jzjpcc_endianness_functions.
- Size: B = 1 byte, H/HU = 2, W = 4. Offset o = byteAddress[1:0]. Misaligned iff o + size > 4 (H at o=3; W at o≠0).
- Aligned: one access at byteAddress[31:2]; mask covers lanes o..o+size-1; store byte i of value goes to offset o+i; unused lanes driven 0.
- Misaligned: first access at word W with lanes o..3; second access at W+1 (wraps 0x3FFFFFFF→0) with remaining low lanes.
- FSM states: IDLE, SECOND. IDLE→SECOND when accessValid and misaligned; SECOND→IDLE unconditionally. Registered in IDLE on a misaligned access: offset, funct3, isStore, word address+1, store value.
- Loads: first-word data captured into a holding register during SECOND; result assembled from holding register (upper bytes) and memReadData. B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
- memWriteEnable = accessValid & isStore (IDLE) or registered isStore (SECOND); memByteMask is 0 when no access is issued.
- No access (accessValid=0 in IDLE): mask 0, write enable 0, address don't-care.

## Timing
- Request outputs are combinational from execute inputs (IDLE) or registers (SECOND), so the backend latches them at the end of the same cycle.
- Aligned load issued in cycle N: loadResult/loadResultValid in N+1. Aligned store: no stall, 0 added latency.
- Misaligned in cycle N: stallRequest=1 in N only; second access in N+1; load result valid in N+2.
- loadResultValid is a registered flag; loadResult is combinational off memReadData and registered metadata.
- While reset is low: state IDLE, holding registers 0, loadResultValid 0, stallRequest 0, memWriteEnable 0, mask 0. Reset during SECOND abandons the second access; no write occurs.
- Execute inputs are ignored in SECOND (they are stalled-stable by contract).

## Structure
- Shared package jzjpcc_memory_access_pkg: funct3 localparams, state enum typedef, size/misalign helper function.
- Optional sub-module jzjpcc_load_extender: combinational lane select + sign/zero extend.

## Test plan
- SW 0x11223344 @0x100 -> address 0x40, mask 1111, data 0x44332211, WE 1, no stall.
- SB 0x...AB @0x103 -> address 0x40, mask 0001, data 0x000000AB.
- LH @0x1003, memory 0x1003=0x01, 0x1004=0x80 -> addresses 0x400 then 0x401, stall one cycle, loadResult 0xFFFF8001 two cycles after issue; LHU gives 0x00008001.
- SW 0xDEADBEEF @0x2001 -> 0x800 mask 0111 data 0x00EFBEAD, then 0x801 mask 1000 data 0xDE000000.
- LB @0x7 reading 0x000000F0 -> 0xFFFFFFF0; LBU -> 0x000000F0; back-to-back aligned loads give results every cycle.
- Reset asserted in SECOND of a misaligned store -> no second write, all outputs 0, next access handled normally.
